// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition BRAM sequencer family.
// Each 64-bit word carries four 16-bit halfwords, each tagged with a sync nibble.
package acq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_REQ,
    RD_WAIT,
    RD_SEND,
    DONE
  } acq_state_t;

  localparam int WORDS_PER_BUF   = 256;
  localparam int HALVES_PER_WORD = 4;
  localparam logic [3:0] SYNC_NIBBLE = 4'hF;

  // One transmitted halfword: sync nibble followed by one nibble per channel.
  function automatic logic [15:0] pack_half(input logic [3:0] n1,
                                            input logic [3:0] n2,
                                            input logic [3:0] n3);
    return {SYNC_NIBBLE, n1, n2, n3};
  endfunction

endpackage

// File: rtl/acq_word_packer.sv
// Packs one three-channel sample into a 64-bit BRAM word, nibble-sliced per halfword.
// Halfword n carries bits [4n+3:4n] of each channel; narrow samples read as zero on top.
module acq_word_packer
  import acq_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] d1,
  input  logic [DATA_WIDTH-1:0] d2,
  input  logic [DATA_WIDTH-1:0] d3,
  output logic [63:0]           word
);

  logic [15:0] e1, e2, e3;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    e1   = 16'(d1);
    e2   = 16'(d2);
    e3   = 16'(d3);
    word = '0;
    for (int n = 0; n < HALVES_PER_WORD; n++) begin
      word[16*n +: 16] = pack_half(e1[4*n +: 4], e2[4*n +: 4], e3[4*n +: 4]);
    end
  end

endmodule

// File: rtl/acq_sequencer.sv
// Ping-pong acquisition controller: fills the BRAM with packed samples, then drains it
// halfword by halfword to the UART with a valid/ready handshake.
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int WR_ADDR_W  = 8,
  parameter int RD_ADDR_W  = 10   // always WR_ADDR_W + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  begin_acq,
  input  logic                  end_acq,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  input  logic [DATA_WIDTH-1:0] data_in_3,
  output logic                  bram_wr_en,
  output logic [WR_ADDR_W-1:0]  bram_wr_addr,
  output logic [63:0]           bram_wr_data,
  output logic                  bram_rd_en,
  output logic [RD_ADDR_W-1:0]  bram_rd_addr,
  input  logic [15:0]           bram_rd_data,
  output logic [15:0]           tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  write_read,
  output logic                  overrun,
  output logic                  ended
);

  localparam int CNT_W = WR_ADDR_W + 1;
  localparam int LIM_W = RD_ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORDS_PER_BUF);

  acq_state_t           state, state_nxt;
  logic [CNT_W-1:0]     wr_cnt, wr_cnt_nxt, cnt_eff;
  logic [RD_ADDR_W-1:0] rd_addr, rd_addr_nxt;
  logic [LIM_W-1:0]     rd_limit, rd_limit_nxt;
  logic                 end_pend, end_pend_nxt;
  logic                 overrun_q, overrun_nxt;
  logic [15:0]          tx_data_q, tx_data_nxt;
  logic                 wr_en, rd_en;
  logic [63:0]          packed_word;

  acq_word_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .d1   (data_in_1),
    .d2   (data_in_2),
    .d3   (data_in_3),
    .word (packed_word)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wr_cnt    <= '0;
      rd_addr   <= '0;
      rd_limit  <= '0;
      end_pend  <= 1'b0;
      overrun_q <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state     <= state_nxt;
      wr_cnt    <= wr_cnt_nxt;
      rd_addr   <= rd_addr_nxt;
      rd_limit  <= rd_limit_nxt;
      end_pend  <= end_pend_nxt;
      overrun_q <= overrun_nxt;
      tx_data_q <= tx_data_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wr_cnt_nxt   = wr_cnt;
    rd_addr_nxt  = rd_addr;
    rd_limit_nxt = rd_limit;
    end_pend_nxt = end_pend;
    overrun_nxt  = overrun_q;
    tx_data_nxt  = tx_data_q;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    // Count as it will stand after this cycle, so a coincident sample is included.
    cnt_eff      = sample_valid ? wr_cnt + CNT_W'(1) : wr_cnt;

    if (!begin_acq) begin
      // Abort: everything returns to idle, any in-flight tx word is dropped.
      state_nxt    = IDLE;
      wr_cnt_nxt   = '0;
      rd_addr_nxt  = '0;
      rd_limit_nxt = '0;
      end_pend_nxt = 1'b0;
      overrun_nxt  = 1'b0;
      tx_data_nxt  = '0;
    end else begin
      if (sample_valid && state != WRITE) begin
        overrun_nxt = 1'b1;
      end

      case (state)
        IDLE: begin
          state_nxt    = WRITE;
          wr_cnt_nxt   = '0;
          rd_addr_nxt  = '0;
          end_pend_nxt = 1'b0;
        end

        WRITE: begin
          if (sample_valid) begin
            wr_en      = 1'b1;
            wr_cnt_nxt = cnt_eff;
          end
          if (end_acq) begin
            end_pend_nxt = 1'b1;
          end
          if (end_acq || cnt_eff == FULL_CNT) begin
            rd_addr_nxt = '0;
            if (cnt_eff == '0) begin
              state_nxt = DONE;
            end else begin
              state_nxt    = RD_REQ;
              rd_limit_nxt = LIM_W'(cnt_eff) * LIM_W'(HALVES_PER_WORD);
            end
          end
        end

        RD_REQ: begin
          rd_en        = 1'b1;
          end_pend_nxt = end_pend | end_acq;
          state_nxt    = RD_WAIT;
        end

        RD_WAIT: begin
          end_pend_nxt = end_pend | end_acq;
          tx_data_nxt  = bram_rd_data;
          state_nxt    = RD_SEND;
        end

        RD_SEND: begin
          end_pend_nxt = end_pend | end_acq;
          if (tx_ready) begin
            if (LIM_W'(rd_addr) == rd_limit - LIM_W'(1)) begin
              if (end_pend_nxt) begin
                state_nxt = DONE;
              end else begin
                state_nxt   = WRITE;
                wr_cnt_nxt  = '0;
                rd_addr_nxt = '0;
              end
            end else begin
              rd_addr_nxt = rd_addr + RD_ADDR_W'(1);
              state_nxt   = RD_REQ;
            end
          end
        end

        DONE: begin
          state_nxt = DONE;
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign bram_wr_en   = wr_en;
  assign bram_wr_addr = wr_cnt[WR_ADDR_W-1:0];
  // Gated so the write bus is quiet whenever no write is issued.
  assign bram_wr_data = wr_en ? packed_word : 64'd0;
  assign bram_rd_en   = rd_en;
  assign bram_rd_addr = rd_addr;
  assign tx_data      = tx_data_q;
  assign tx_valid     = (state == RD_SEND);
  assign write_read   = (state == RD_REQ) || (state == RD_WAIT) ||
                        (state == RD_SEND) || (state == DONE);
  assign overrun      = overrun_q;
  assign ended        = (state == DONE);

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer with a behavioural dual-port BRAM beside it.
// Inputs change 1 ns after the rising edge; the per-cycle monitor samples on the falling edge.
module tb_acq_sequencer;

  logic        clk;
  logic        rst;
  logic        begin_acq, end_acq, sample_valid;
  logic [15:0] data_in_1, data_in_2, data_in_3;
  logic        bram_wr_en;
  logic [7:0]  bram_wr_addr;
  logic [63:0] bram_wr_data;
  logic        bram_rd_en;
  logic [9:0]  bram_rd_addr;
  logic [15:0] bram_rd_data;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready;
  logic        write_read, overrun, ended;

  int errors = 0;
  int checks = 0;
  int wr_count, rd_en_count, tx_count;
  logic [15:0] exp_half [4];
  logic [63:0] mem [256];

  acq_sequencer #(.DATA_WIDTH(16), .WR_ADDR_W(8), .RD_ADDR_W(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .begin_acq    (begin_acq),
    .end_acq      (end_acq),
    .sample_valid (sample_valid),
    .data_in_1    (data_in_1),
    .data_in_2    (data_in_2),
    .data_in_3    (data_in_3),
    .bram_wr_en   (bram_wr_en),
    .bram_wr_addr (bram_wr_addr),
    .bram_wr_data (bram_wr_data),
    .bram_rd_en   (bram_rd_en),
    .bram_rd_addr (bram_rd_addr),
    .bram_rd_data (bram_rd_data),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .write_read   (write_read),
    .overrun      (overrun),
    .ended        (ended)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM: 64-bit write port, 16-bit read port with one cycle of latency.
  always @(posedge clk) begin
    if (bram_wr_en) mem[bram_wr_addr] <= bram_wr_data;
    if (bram_rd_en) bram_rd_data <= mem[bram_rd_addr[9:2]][16*bram_rd_addr[1:0] +: 16];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: monitor on the falling edge, then return just after the rising edge.
  task automatic step();
    @(negedge clk);
    if (bram_wr_en) begin
      check("wr_addr", {56'd0, bram_wr_addr}, 64'(wr_count % 256));
      wr_count++;
    end
    if (bram_rd_en) rd_en_count++;
    if (tx_valid && tx_ready) begin
      check("tx_data", {48'd0, tx_data}, {48'd0, exp_half[tx_count % 4]});
      tx_count++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    wr_count    = 0;
    rd_en_count = 0;
    tx_count    = 0;
  endtask

  task automatic wait_ended(input string tag, input int budget);
    int n = 0;
    while (!ended && n < budget) begin step(); n++; end
    check(tag, {63'd0, ended}, 64'd1);
  endtask

  task automatic wait_tx_valid(input string tag, input int budget);
    int n = 0;
    while (!tx_valid && n < budget) begin step(); n++; end
    check(tag, {63'd0, tx_valid}, 64'd1);
  endtask

  initial begin
    rst = 1'b0; begin_acq = 1'b0; end_acq = 1'b0; sample_valid = 1'b0; tx_ready = 1'b1;
    data_in_1 = 16'h0123; data_in_2 = 16'h0456; data_in_3 = 16'h0789;
    exp_half[0] = 16'hF369; exp_half[1] = 16'hF258; exp_half[2] = 16'hF147; exp_half[3] = 16'hF000;
    clear_counts();
    step(); step();

    // Reset state
    check("rst_wr_en",      {63'd0, bram_wr_en}, 64'd0);
    check("rst_wr_data",    bram_wr_data,        64'd0);
    check("rst_rd_en",      {63'd0, bram_rd_en}, 64'd0);
    check("rst_rd_addr",    {54'd0, bram_rd_addr}, 64'd0);
    check("rst_tx_valid",   {63'd0, tx_valid},   64'd0);
    check("rst_tx_data",    {48'd0, tx_data},    64'd0);
    check("rst_write_read", {63'd0, write_read}, 64'd0);
    check("rst_overrun",    {63'd0, overrun},    64'd0);
    check("rst_ended",      {63'd0, ended},      64'd0);

    // Full buffer: 256 words, 1024 halfwords, then ping-pong back to WRITE
    rst = 1'b1;
    begin_acq = 1'b1;
    step();
    check("full_in_write", {63'd0, write_read}, 64'd0);
    sample_valid = 1'b1;
    for (int i = 0; i < 256; i++) step();
    sample_valid = 1'b0;
    check("full_wr_count", 64'(wr_count), 64'd256);
    check("full_read_phase", {63'd0, write_read}, 64'd1);
    begin
      int n = 0;
      while (write_read && n < 5000) begin step(); n++; end
    end
    check("full_back_to_write", {63'd0, write_read}, 64'd0);
    check("full_tx_count", 64'(tx_count), 64'd1024);
    check("full_rd_en_count", 64'(rd_en_count), 64'd1024);
    check("full_wr_addr_zero", {56'd0, bram_wr_addr}, 64'd0);
    check("full_not_ended", {63'd0, ended}, 64'd0);

    // Partial end: 5 words -> 20 halfwords, then DONE
    clear_counts();
    data_in_1 = 16'hABCD; data_in_2 = 16'h1234; data_in_3 = 16'h5678;
    exp_half[0] = 16'hFD48; exp_half[1] = 16'hFC37; exp_half[2] = 16'hFB26; exp_half[3] = 16'hFA15;
    sample_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    sample_valid = 1'b0;
    end_acq = 1'b1;
    step();
    end_acq = 1'b0;
    wait_ended("part_ended", 200);
    check("part_tx_count", 64'(tx_count), 64'd20);
    check("part_wr_count", 64'(wr_count), 64'd5);
    check("part_write_read", {63'd0, write_read}, 64'd1);
    sample_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("part_done_wr_count", 64'(wr_count), 64'd5);
    check("part_done_tx_count", 64'(tx_count), 64'd20);
    check("part_done_rd_en", 64'(rd_en_count), 64'd20);

    // Simultaneous sample and end_acq after two samples
    begin_acq = 1'b0;
    step();
    check("sim_idle_ended", {63'd0, ended}, 64'd0);
    begin_acq = 1'b1;
    step();
    clear_counts();
    data_in_1 = 16'h0123; data_in_2 = 16'h0456; data_in_3 = 16'h0789;
    exp_half[0] = 16'hF369; exp_half[1] = 16'hF258; exp_half[2] = 16'hF147; exp_half[3] = 16'hF000;
    sample_valid = 1'b1;
    step(); step();
    end_acq = 1'b1;
    step();
    sample_valid = 1'b0; end_acq = 1'b0;
    wait_ended("sim_ended", 100);
    check("sim_wr_count", 64'(wr_count), 64'd3);
    check("sim_tx_count", 64'(tx_count), 64'd12);

    // Backpressure, then abort during RD_SEND
    begin_acq = 1'b0; step();
    begin_acq = 1'b1; step();
    clear_counts();
    data_in_1 = 16'hABCD; data_in_2 = 16'h1234; data_in_3 = 16'h5678;
    exp_half[0] = 16'hFD48; exp_half[1] = 16'hFC37; exp_half[2] = 16'hFB26; exp_half[3] = 16'hFA15;
    tx_ready = 1'b0;
    sample_valid = 1'b1;
    step(); step();
    sample_valid = 1'b0;
    end_acq = 1'b1;
    step();
    end_acq = 1'b0;
    wait_tx_valid("bp_first_valid", 20);
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold_valid", {63'd0, tx_valid}, 64'd1);
      check("bp_hold_data", {48'd0, tx_data}, 64'h0000_0000_0000_FD48);
    end
    check("bp_rd_en_count", 64'(rd_en_count), 64'd1);
    check("bp_rd_addr", {54'd0, bram_rd_addr}, 64'd0);
    check("bp_tx_count", 64'(tx_count), 64'd0);
    tx_ready = 1'b1;
    begin
      int n = 0;
      while (tx_count < 3 && n < 50) begin step(); n++; end
    end
    check("bp_three_sent", 64'(tx_count), 64'd3);
    tx_ready = 1'b0;
    wait_tx_valid("abort_valid", 20);
    check("abort_rd_addr", {54'd0, bram_rd_addr}, 64'd3);
    check("abort_pre_data", {48'd0, tx_data}, 64'h0000_0000_0000_FA15);
    begin_acq = 1'b0;
    step();
    check("abort_tx_valid", {63'd0, tx_valid}, 64'd0);
    check("abort_tx_data", {48'd0, tx_data}, 64'd0);
    check("abort_write_read", {63'd0, write_read}, 64'd0);
    check("abort_ended", {63'd0, ended}, 64'd0);
    check("abort_rd_en", {63'd0, bram_rd_en}, 64'd0);
    check("abort_rd_addr0", {54'd0, bram_rd_addr}, 64'd0);
    tx_ready = 1'b1;
    begin_acq = 1'b1;
    step();
    clear_counts();
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    check("restart_wr_count", 64'(wr_count), 64'd1);

    // Overrun: strobe during a read phase is discarded and flagged
    check("ovr_clear", {63'd0, overrun}, 64'd0);
    end_acq = 1'b1;
    step();
    end_acq = 1'b0;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    check("ovr_set", {63'd0, overrun}, 64'd1);
    check("ovr_no_write", 64'(wr_count), 64'd1);
    wait_ended("ovr_ended", 50);
    check("ovr_tx_count", 64'(tx_count), 64'd4);
    check("ovr_sticky", {63'd0, overrun}, 64'd1);

    // Zero-length: end_acq with nothing written goes straight to DONE
    begin_acq = 1'b0; step();
    check("zero_ovr_cleared", {63'd0, overrun}, 64'd0);
    begin_acq = 1'b1; step();
    clear_counts();
    end_acq = 1'b1;
    step();
    end_acq = 1'b0;
    check("zero_ended", {63'd0, ended}, 64'd1);
    check("zero_write_read", {63'd0, write_read}, 64'd1);
    for (int i = 0; i < 5; i++) step();
    check("zero_tx_count", 64'(tx_count), 64'd0);
    check("zero_rd_en_count", 64'(rd_en_count), 64'd0);

    // Asynchronous reset in the middle of a write phase
    begin_acq = 1'b0; step();
    begin_acq = 1'b1; step();
    clear_counts();
    sample_valid = 1'b1;
    step(); step(); step();
    check("arst_pre_wr_en", {63'd0, bram_wr_en}, 64'd1);
    check("arst_pre_wr_addr", {56'd0, bram_wr_addr}, 64'd3);
    #2 rst = 1'b0;
    #1;
    check("arst_wr_en", {63'd0, bram_wr_en}, 64'd0);
    check("arst_wr_addr", {56'd0, bram_wr_addr}, 64'd0);
    check("arst_wr_data", bram_wr_data, 64'd0);
    check("arst_write_read", {63'd0, write_read}, 64'd0);
    check("arst_tx_valid", {63'd0, tx_valid}, 64'd0);
    sample_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
